// File: rtl/tx_serializer_pkg.sv
// Shared types and constants for the console serial transmitter.
package tx_serializer_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/tx_serializer_fifo.sv
// Character buffer: show-ahead synchronous FIFO with an exact occupancy count.
module sync_fifo
  import tx_serializer_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_serializer.sv
// Buffered console transmitter: FIFO-fed framer producing start, LSB-first data,
// optional parity and stop bits on an idle-high registered serial line.
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        wr_en,
  input  logic                        clr_err,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  tx_state_t            state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] fifo_data;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_n;
  logic                 pop;
  logic                 bit_end;

  assign bit_end = (timer == TW'(CLKS_PER_BIT - 1));
  assign busy    = (state != TX_IDLE);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en & ~full),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky overflow: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (clr_err)       overflow <= 1'b0;
  end

  // Framer state, bit timer, shift register and registered line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TX_IDLE;
      timer    <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_bit_n;
      tx       <= tx_n;
    end
  end

  // Next-state logic; tx_n is the level for the bit entered on the next edge.
  // Loading a new character is shared by IDLE and the last stop bit so that
  // back-to-back frames start with no idle bit between them.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_bit_n  = par_bit;
    tx_n       = tx;
    pop        = 1'b0;

    if (state != TX_IDLE) timer_n = bit_end ? '0 : timer + 1'b1;

    case (state)
      TX_IDLE: begin
        timer_n = '0;
        tx_n    = 1'b1;
        if (!empty) pop = 1'b1;
      end
      TX_START: begin
        if (bit_end) begin
          state_n   = TX_DATA;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              state_n = TX_PAR;
              tx_n    = par_bit;
            end else begin
              state_n    = TX_STOP;
              stop_cnt_n = 1'b0;
              tx_n       = 1'b1;
            end
          end else begin
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      TX_PAR: begin
        if (bit_end) begin
          state_n    = TX_STOP;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_n = TX_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = TX_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (pop) begin
      shreg_n   = fifo_data;
      par_bit_n = (^fifo_data) ^ (PARITY == PAR_ODD);
      state_n   = TX_START;
      timer_n   = '0;
      tx_n      = 1'b0;
    end
  end

endmodule
